// File: rtl/wb_arbiter.sv
// Write-port arbiter: the primary (ALU) writer always owns the register-file port; secondary
// writes wait in a small FIFO with kill-on-overwrite, starvation stall and bypass lookup.
module wb_arbiter #(
   parameter int DEPTH  = 4,
   parameter int STARVE = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        a_valid_i,
   input  logic [4:0]  a_rd_i,
   input  logic [31:0] a_data_i,
   output logic        a_stall_o,
   input  logic        b_valid_i,
   output logic        b_ready_o,
   input  logic [4:0]  b_rd_i,
   input  logic [31:0] b_data_i,
   output logic        en3_o,
   output logic [4:0]  ch3_o,
   output logic [31:0] data3_o,
   input  logic [4:0]  q1_ch_i,
   input  logic [4:0]  q2_ch_i,
   output logic        q1_hit_o,
   output logic        q2_hit_o,
   output logic [31:0] q1_data_o,
   output logic [31:0] q2_data_o,
   output logic [2:0]  pending_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE + 1);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [4:0]       rd_q   [DEPTH];
   logic [4:0]       rd_d   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             en3_q, en3_d;
   logic [4:0]       ch3_q, ch3_d;
   logic [31:0]      data3_q, data3_d;

   logic             a_wr_s, pop_s, push_s;
   logic [1:0]       q_hit_s;
   logic [31:0]      q_data_s [2];
   logic [4:0]       q_ch_s   [2];
   logic [PW-1:0]    idx_s;
   logic             match_s;

   assign a_wr_s    = a_valid_i && (a_rd_i != 5'd0);
   assign pop_s     = (cnt_q != {CW{1'b0}}) && !a_valid_i;
   assign b_ready_o = rst_i || (cnt_q < CW'(DEPTH));
   assign push_s    = b_valid_i && b_ready_o && (b_rd_i != 5'd0);
   assign a_stall_o = !rst_i && (starve_q == SW'(STARVE));
   assign pending_o = 3'(cnt_q);
   assign en3_o     = en3_q;
   assign ch3_o     = ch3_q;
   assign data3_o   = data3_q;

   // Next state: kill stale entries on A, then pop head / push tail, then pick the write-port source.
   always_comb begin
      rd_d     = rd_q;
      data_d   = data_q;
      head_d   = head_q;
      tail_d   = tail_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;
      en3_d    = 1'b0;
      ch3_d    = ch3_q;
      data3_d  = data3_q;
      for (int i = 0; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i] && !(a_wr_s && (rd_q[i] == a_rd_i));
      end
      if (pop_s) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PW'(1);
      end else begin
         head_d = head_q;
      end
      // The pushed entry is younger than the concurrent A, so it is never killed by it.
      if (push_s) begin
         valid_d[tail_q] = 1'b1;
         rd_d[tail_q]    = b_rd_i;
         data_d[tail_q]  = b_data_i;
         tail_d          = tail_q + PW'(1);
      end else begin
         tail_d = tail_q;
      end
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      if (pop_s || (cnt_q == {CW{1'b0}})) begin
         starve_d = {SW{1'b0}};
      end else if (starve_q != SW'(STARVE)) begin
         starve_d = starve_q + SW'(1);
      end else begin
         starve_d = starve_q;
      end
      if (a_valid_i) begin
         en3_d = a_wr_s;
         if (a_wr_s) begin
            ch3_d   = a_rd_i;
            data3_d = a_data_i;
         end else begin
            ch3_d   = ch3_q;
            data3_d = data3_q;
         end
      end else if (pop_s) begin
         en3_d = valid_q[head_q];
         if (valid_q[head_q]) begin
            ch3_d   = rd_q[head_q];
            data3_d = data_q[head_q];
         end else begin
            ch3_d   = ch3_q;
            data3_d = data3_q;
         end
      end else begin
         en3_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q  <= {DEPTH{1'b0}};
         rd_q     <= '{default: 5'd0};
         data_q   <= '{default: 32'd0};
         head_q   <= {PW{1'b0}};
         tail_q   <= {PW{1'b0}};
         cnt_q    <= {CW{1'b0}};
         starve_q <= {SW{1'b0}};
         en3_q    <= 1'b0;
         ch3_q    <= 5'd0;
         data3_q  <= 32'd0;
      end else begin
         valid_q  <= valid_d;
         rd_q     <= rd_d;
         data_q   <= data_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         en3_q    <= en3_d;
         ch3_q    <= ch3_d;
         data3_q  <= data3_d;
      end
   end

   // Bypass lookup: scanning from head gives age order, so the last valid match is the youngest.
   always_comb begin
      q_ch_s[0] = q1_ch_i;
      q_ch_s[1] = q2_ch_i;
      q_hit_s   = 2'b00;
      idx_s     = {PW{1'b0}};
      match_s   = 1'b0;
      for (int k = 0; k < 2; k++) begin
         q_hit_s[k]  = en3_q && (ch3_q == q_ch_s[k]);
         q_data_s[k] = data3_q;
         for (int i = 0; i < DEPTH; i++) begin
            idx_s       = head_q + PW'(i);
            match_s     = valid_q[idx_s] && (rd_q[idx_s] == q_ch_s[k]);
            q_hit_s[k]  = q_hit_s[k] | match_s;
            q_data_s[k] = match_s ? data_q[idx_s] : q_data_s[k];
         end
         if (rst_i || (q_ch_s[k] == 5'd0)) begin
            q_hit_s[k]  = 1'b0;
            q_data_s[k] = 32'd0;
         end else begin
            q_hit_s[k]  = q_hit_s[k];
            q_data_s[k] = q_data_s[k];
         end
      end
   end

   assign q1_hit_o  = q_hit_s[0];
   assign q2_hit_o  = q_hit_s[1];
   assign q1_data_o = q_data_s[0];
   assign q2_data_o = q_data_s[1];

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized plus directed bench for wb_arbiter, checked every cycle against a queue-based model.
module tb_wb_arbiter;
   localparam int DEPTH  = 4;
   localparam int STARVE = 8;

   logic        clk = 1'b0;
   logic        rst, a_valid, a_stall, b_valid, b_ready, en3, q1_hit, q2_hit;
   logic [4:0]  a_rd, b_rd, ch3, q1_ch, q2_ch;
   logic [31:0] a_data, b_data, data3, q1_data, q2_data;
   logic [2:0]  pending;

   wb_arbiter #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
      .clk_i(clk), .rst_i(rst), .a_valid_i(a_valid), .a_rd_i(a_rd), .a_data_i(a_data),
      .a_stall_o(a_stall), .b_valid_i(b_valid), .b_ready_o(b_ready), .b_rd_i(b_rd),
      .b_data_i(b_data), .en3_o(en3), .ch3_o(ch3), .data3_o(data3), .q1_ch_i(q1_ch),
      .q2_ch_i(q2_ch), .q1_hit_o(q1_hit), .q2_hit_o(q2_hit), .q1_data_o(q1_data),
      .q2_data_o(q2_data), .pending_o(pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          vld;
   } ent_t;

   ent_t        mq[$];
   int          m_sc = 0;
   bit          m_en3 = 1'b0;
   bit          m_known = 1'b1;
   logic [4:0]  m_ch3 = 5'd0;
   logic [31:0] m_data3 = 32'd0;
   int          n_total = 0;
   int          n_pass = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic void m_bypass(input logic [4:0] ch, output bit hit, output logic [31:0] d);
      hit = 1'b0;
      d   = m_data3;
      if (rst || ch == 5'd0) begin
         d = 32'd0;
         return;
      end
      if (m_en3 && m_ch3 == ch) hit = 1'b1;
      foreach (mq[i]) begin
         if (mq[i].vld && mq[i].rd == ch) begin
            hit = 1'b1;
            d   = mq[i].data;
         end
      end
   endfunction

   task automatic cycle_check();
      bit          eh;
      logic [31:0] ed;
      check_val("b_ready", b_ready, rst || mq.size() < DEPTH);
      check_val("a_stall", a_stall, !rst && m_sc == STARVE);
      check_val("pending", pending, mq.size());
      check_val("en3", en3, m_en3);
      if (m_known) begin
         check_val("ch3", ch3, m_ch3);
         check_val("data3", data3, m_data3);
      end
      m_bypass(q1_ch, eh, ed);
      check_val("q1_hit", q1_hit, eh);
      if (eh || q1_ch == 5'd0) check_val("q1_data", q1_data, ed);
      m_bypass(q2_ch, eh, ed);
      check_val("q2_hit", q2_hit, eh);
      if (eh || q2_ch == 5'd0) check_val("q2_data", q2_data, ed);
   endtask

   task automatic model_update();
      int   pre_n;
      bit   pop;
      ent_t e;
      if (rst) begin
         mq.delete();
         m_sc = 0; m_en3 = 1'b0; m_ch3 = 5'd0; m_data3 = 32'd0; m_known = 1'b1;
         return;
      end
      pre_n = mq.size();
      pop   = pre_n > 0 && !a_valid;
      if (a_valid) begin
         if (a_rd != 5'd0) begin
            m_en3 = 1'b1; m_ch3 = a_rd; m_data3 = a_data; m_known = 1'b1;
            foreach (mq[i]) if (mq[i].rd == a_rd) mq[i].vld = 1'b0;
         end else begin
            m_en3 = 1'b0; m_known = 1'b0;
         end
      end else if (pop) begin
         e = mq.pop_front();
         if (e.vld) begin
            m_en3 = 1'b1; m_ch3 = e.rd; m_data3 = e.data; m_known = 1'b1;
         end else begin
            m_en3 = 1'b0; m_known = 1'b0;
         end
      end else begin
         m_en3 = 1'b0;
      end
      if (pop || pre_n == 0) m_sc = 0;
      else if (m_sc < STARVE) m_sc++;
      if (b_valid && pre_n < DEPTH && b_rd != 5'd0) begin
         e.rd = b_rd; e.data = b_data; e.vld = 1'b1;
         mq.push_back(e);
      end
   endtask

   task automatic step();
      #1;
      cycle_check();
      model_update();
      @(negedge clk);
   endtask

   task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit bv, input logic [4:0] brd, input logic [31:0] bd,
                        input logic [4:0] c1);
      a_valid = av; a_rd = ard; a_data = ad;
      b_valid = bv; b_rd = brd; b_data = bd;
      q1_ch = c1; q2_ch = brd;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      rst = 1'b1; a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
      b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0; q1_ch = 5'd3; q2_ch = 5'd0;
      @(negedge clk);
      check_val("rst_en3", en3, 1'b0);
      check_val("rst_data3", data3, 32'd0);
      step();
      rst = 1'b0;

      // Single A write, latency 1
      drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 5'd5);
      check_val("a_en3", en3, 1'b1);
      check_val("a_ch3", ch3, 5'd5);
      check_val("a_data3", data3, 32'h11);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
      check_val("a_en3_off", en3, 1'b0);

      // Fill the queue while A holds the port with rd 0
      for (int i = 1; i <= 4; i++) drive(1'b1, 5'd0, 32'd0, 1'b1, 5'(i), 32'(i * 16), 5'd2);
      check_val("fill_pending", pending, 3'd4);
      check_val("fill_ready", b_ready, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'(i));
         check_val("drain_ch3", ch3, 5'(i));
         check_val("drain_ready", b_ready, 1'b1);
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);

      // Kill: newer A to rd7 cancels the older queued B
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA, 5'd7);
      drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd7);
      check_val("kill_q1_data", q1_data, 32'hBB);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
      check_val("kill_pop_en3", en3, 1'b0);
      check_val("kill_q1_hit", q1_hit, 1'b0);

      // Starvation: one queued B, A busy until stall
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99, 5'd9);
      k = 0;
      while (!a_stall && k < 20) begin
         drive(1'b1, 5'd3, 32'(k), 1'b0, 5'd0, 32'd0, 5'd9);
         k++;
      end
      check_val("starve_cycles", k, 8);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9);
      check_val("starve_wr_ch3", ch3, 5'd9);
      check_val("starve_clear", a_stall, 1'b0);

      // Zero register requests
      for (int i = 0; i < 3; i++) drive(1'(i % 2), 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 5'd0);

      // Reset with three entries queued
      for (int i = 1; i <= 3; i++) drive(1'b1, 5'd0, 32'd0, 1'b1, 5'(i + 10), 32'(i), 5'd11);
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11);
      rst = 1'b0;
      check_val("rst_pending", pending, 3'd0);
      for (int i = 0; i < 4; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12);

      // Randomized traffic; A mostly respects the stall
      for (int c = 0; c < 1500; c++) begin
         rst     = ($urandom_range(0, 199) == 0);
         a_valid = (!rst && m_sc == STARVE) ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
         a_rd    = 5'($urandom_range(0, 7));
         a_data  = $urandom;
         b_valid = 1'($urandom_range(0, 2) != 0);
         b_rd    = 5'($urandom_range(0, 7));
         b_data  = $urandom;
         q1_ch   = 5'($urandom_range(0, 7));
         q2_ch   = 5'($urandom_range(0, 7));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL define parameter DEPTH, default 4, secondary write-queue entries (power of two, ≥2).
REQ-002 SHALL define parameter STARVE, default 8, cycles a queued entry may wait before A is stalled.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_valid  input  1  primary (ALU) write request; no ready, always accepted.
REQ-006 a_rd / a_data  input  5 / 32  primary destination register / value.
REQ-007 a_stall  output  1  upstream must hold a_valid=0 while high.
REQ-008 b_valid / b_ready  input / output  1 / 1  secondary (multi-cycle/load unit) handshake; transfer when both high at posedge.
REQ-009 b_rd / b_data  input  5 / 32  secondary destination register / value.
REQ-010 en3 / ch3 / data3  output  1 / 5 / 32  registered register-file write port; file samples on negedge clk.
REQ-011 q1_ch, q2_ch  input  5 each  bypass query register numbers.
REQ-012 q1_hit, q2_hit / q1_data, q2_data  output  1 / 32 each  combinational bypass results.
REQ-013 pending  output  3  count of queue slots occupied (valid or killed).

Function
REQ-014 Cycle with a_valid=1, a_rd≠0 SHALL give en3=1, ch3=a_rd, data3=a_data in the next cycle (latency 1).
REQ-015 a_valid with a_rd=0 SHALL produce en3=0 next cycle; never write register 0.
REQ-016 b_ready SHALL equal (pending<DEPTH); no same-cycle pop lookahead.
REQ-017 Accepted B with b_rd=0 SHALL be dropped, not enqueued.
REQ-018 Accepted B with b_rd≠0 SHALL enqueue at tail, marked valid, visible next cycle.
REQ-019 Queue head SHALL pop in any cycle with pending>0 and a_valid=0; valid head gives en3=1, ch3/data3 = entry next cycle; killed head gives en3=0.
REQ-020 A SHALL always win the write port over the queue.
REQ-021 Cycle with neither A nor pop SHALL give en3=0 next cycle; ch3/data3 hold previous values.
REQ-022 a_valid with a_rd≠0 SHALL kill (mark invalid) every queued entry whose rd equals a_rd, so older B never overwrites newer A.
REQ-023 B accepted in the same cycle as a matching A SHALL be treated as younger: enqueued valid, not killed.
REQ-024 Simultaneous push and pop SHALL keep pending unchanged; pointers wrap modulo DEPTH.
REQ-025 Starve counter SHALL increment each cycle pending>0 and no pop, saturating at STARVE; clear on pop or pending=0.
REQ-026 a_stall SHALL be 1 exactly while starve counter = STARVE.
REQ-027 a_valid=1 while a_stall=1 is a protocol violation; block SHALL still give A priority and stay consistent.
REQ-028 qN_hit SHALL be 1 when qN_ch≠0 and matches a valid queue entry or (en3=1 and ch3); qN_data from youngest matching valid queue entry, else data3.
REQ-029 qN_ch=0 SHALL give qN_hit=0, qN_data=0.

Reset
REQ-030 rst=1 at posedge SHALL set en3=0, ch3=0, data3=0, pending=0, pointers=0, all entries invalid, starve counter=0.
REQ-031 During and after reset SHALL give b_ready=1, a_stall=0, q1_hit=q2_hit=0.
REQ-032 Reset mid-operation SHALL discard all queued writes; no write issued in the cycle after reset.

Verification
REQ-033 A: a_valid=1, a_rd=5, a_data=0x11 at cycle 0 -> cycle 1 en3=1, ch3=5, data3=0x11; cycle 2 en3=0.
REQ-034 Fill: push B rd=1..4 on 4 idle-A cycles with a_valid=1 held -> b_ready=0 after 4th, pending=4; drop a_valid -> writes rd1..rd4 in order, one per cycle, b_ready rises after first pop.
REQ-035 Kill: queue B rd=7 data=0xAA, then A rd=7 data=0xBB -> only write of rd7 is 0xBB; queue slot pops with en3=0; q1_ch=7 after kill hits data3=0xBB only during en3 cycle.
REQ-036 Starvation: one queued B, a_valid=1 continuously -> a_stall=1 after 8 cycles; a_valid=0 next -> B written, a_stall=0.
REQ-037 Zero register: a_rd=0 and b_rd=0 requests -> en3 never 1 with ch3=0; pending stays 0.
REQ-038 Reset: 3 entries queued, rst=1 one cycle -> en3=0, pending=0, b_ready=1; no queued write ever appears.
